fsm_step_arbiter: RTL and testbench

Arbitrates two requesters that each want the shared 8-position ring FSM (positions 0..7, forward = +1 mod 8, backward = -1 mod 8) moved to a target position. Sequences the ring one step per handshake along the shortest path and keeps a mirror of the ring's current position. Sits between the requesting control logic and the ring FSM's step interface.

---
 rtl/fsm_step_arbiter.sv | 119 +++++++++++
 tb/tb_fsm_step_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_step_arbiter.sv
`timescale 1ns/1ps
// fsm_step_arbiter: grants one of two requesters the shared 8-position ring
// and walks the ring to the granted target one step per handshake, always
// along the shortest path. It also keeps a local mirror of the ring position.
module fsm_step_arbiter (
  input  logic       c,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [5:0] req_target,
  output logic [1:0] req_ready,
  output logic       step_valid,
  output logic       step_dir,
  input  logic       step_ready,
  output logic [2:0] pos,
  output logic       busy,
  output logic       done,
  output logic       done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_pos;
  logic [2:0] r_tgt;
  logic       r_id;
  logic       r_last;

  logic       w_win;
  logic       w_acc;
  logic [2:0] w_tgt_in;
  logic [2:0] w_dist;
  logic       w_fwd;
  logic [2:0] w_pos_nxt;

  // Round-robin winner. Under contention the requester not granted last wins.
  always_comb begin
    w_win = req_valid[1];
    if (req_valid == 2'b11) begin
      w_win = ~r_last;
    end
    w_tgt_in = w_win ? req_target[5:3] : req_target[2:0];
  end

  // Shortest-path direction and next ring position. A distance of 4 is a tie
  // and is taken forward.
  always_comb begin
    w_dist    = r_tgt - r_pos;
    w_fwd     = (w_dist != 3'd0) && (w_dist <= 3'd4);
    w_pos_nxt = w_fwd ? (r_pos + 3'd1) : (r_pos - 3'd1);
  end

  // Next-state logic and the combinational grant, which is only offered in IDLE.
  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    w_acc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = w_win ? 2'b10 : 2'b01;
          w_acc     = 1'b1;
          w_next    = (w_tgt_in == r_pos) ? DONE : STEP;
        end
      end
      STEP: begin
        if (step_ready) begin
          w_next = (w_pos_nxt == r_tgt) ? DONE : STEP;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Control state: FSM, position mirror, served id and the last-grant pointer.
  // The pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge c or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pos   <= 3'd0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_id   <= w_win;
        r_last <= w_win;
      end
      if ((r_state == STEP) && step_ready) begin
        r_pos <= w_pos_nxt;
      end
    end
  end

  // Latched target; only meaningful after an accept, so it carries no reset.
  always_ff @(posedge c) begin
    if (w_acc) begin
      r_tgt <= w_tgt_in;
    end
  end

  // Outputs decode from registered state, so reset clears them at once.
  assign step_valid = (r_state == STEP);
  assign step_dir   = step_valid & w_fwd;
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == DONE);
  assign done_id    = done & r_id;
  assign pos        = r_pos;

endmodule

// File: tb/tb_fsm_step_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for fsm_step_arbiter: each accepted request pushes its
// predicted move (winner, target, step count, direction); the move is tracked
// cycle by cycle and the entry is popped and compared when done pulses.
module tb_fsm_step_arbiter;

  logic       c = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [5:0] req_target = 6'd0;
  logic       step_ready = 1'b1;
  logic [1:0] req_ready;
  logic       step_valid;
  logic       step_dir;
  logic [2:0] pos;
  logic       busy;
  logic       done;
  logic       done_id;

  fsm_step_arbiter dut (
    .c          (c),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .step_valid (step_valid),
    .step_dir   (step_dir),
    .step_ready (step_ready),
    .pos        (pos),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id)
  );

  always #5 c = ~c;

  typedef struct {
    logic       id;
    logic [2:0] tgt;
    int         steps;
    logic       dir;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [2:0] m_pos = 3'd0;
  logic       m_last = 1'b1;

  // Apply reset for one cycle from IDLE and check the reset outputs.
  task automatic test_reset_idle();
    @(negedge c);
    rst = 1'b0;
    req_valid = 2'b00;
    step_ready = 1'b1;
    #1;
    vectors++;
    if ({req_ready, step_valid, step_dir, busy, done, done_id, pos} !== 10'd0) begin
      $display("FAIL reset_idle: outputs got %b want 0", {req_ready, step_valid, step_dir, busy, done, done_id, pos});
      miscompares++;
    end
    @(negedge c);
    rst = 1'b1;
    m_pos = 3'd0;
    m_last = 1'b1;
    sb.delete();
  endtask

  // One request/move. vld selects active requesters, late ORs extra request
  // bits in while the move is busy, keep leaves req_valid asserted afterwards.
  task automatic run_move(input logic [1:0] vld, input logic [2:0] t0, input logic [2:0] t1,
                          input int stall, input bit keep, input logic [1:0] late, input string nm);
    exp_t       e;
    logic       w;
    logic [2:0] d;
    int         cyc;
    int         stalls_left;
    bit         fin;
    @(negedge c);
    req_target = {t1, t0};
    req_valid  = vld;
    w = (vld == 2'b11) ? ~m_last : vld[1];
    e.id  = w;
    e.tgt = w ? t1 : t0;
    d = e.tgt - m_pos;
    if (d == 3'd0)       e.steps = 0;
    else if (d <= 3'd4)  e.steps = int'(d);
    else                 e.steps = 8 - int'(d);
    e.dir = (d != 3'd0) && (d <= 3'd4);
    sb.push_back(e);
    m_last = w;
    #1;
    vectors++;
    if (req_ready !== (w ? 2'b10 : 2'b01)) begin
      $display("FAIL %s grant: req_ready got %b want %b", nm, req_ready, (w ? 2'b10 : 2'b01));
      miscompares++;
    end
    @(negedge c);
    if (!keep) req_valid = 2'b00;
    cyc = 1;
    stalls_left = stall;
    fin = 1'b0;
    while (!fin && cyc <= 40) begin
      if (cyc == 1) req_valid = req_valid | late;
      #1;
      vectors++;
      if (busy !== 1'b1 || req_ready !== 2'b00) begin
        $display("FAIL %s busy: busy=%b req_ready=%b want busy=1 req_ready=00 (cycle %0d)", nm, busy, req_ready, cyc);
        miscompares++;
      end
      if (done === 1'b1) begin
        e = sb.pop_front();
        vectors++;
        if (done_id !== e.id || pos !== e.tgt || step_valid !== 1'b0) begin
          $display("FAIL %s done: id=%b pos=%0d sv=%b want id=%b pos=%0d sv=0", nm, done_id, pos, step_valid, e.id, e.tgt);
          miscompares++;
        end
        vectors++;
        if (cyc != e.steps + stall + 1) begin
          $display("FAIL %s latency: done at t+%0d want t+%0d", nm, cyc, e.steps + stall + 1);
          miscompares++;
        end
        fin = 1'b1;
      end else if (step_valid === 1'b1) begin
        vectors++;
        if (step_dir !== sb[0].dir || pos !== m_pos) begin
          $display("FAIL %s step: dir=%b pos=%0d want dir=%b pos=%0d", nm, step_dir, pos, sb[0].dir, m_pos);
          miscompares++;
        end
        if (stalls_left > 0) begin
          step_ready = 1'b0;
          stalls_left--;
        end else begin
          step_ready = 1'b1;
          m_pos = m_pos + (sb[0].dir ? 3'd1 : 3'd7);
        end
      end else begin
        vectors++;
        $display("FAIL %s state: neither step_valid nor done at t+%0d", nm, cyc);
        miscompares++;
      end
      if (!fin) begin
        @(negedge c);
        cyc++;
      end
    end
    if (!fin) begin
      vectors++;
      $display("FAIL %s timeout: no done within 40 cycles", nm);
      miscompares++;
      sb.delete();
    end
    step_ready = 1'b1;
  endtask

  // Reset asserted mid-move while step_valid is high.
  task automatic test_reset();
    test_reset_idle();
    @(negedge c);
    req_target = {3'd0, 3'd5};
    req_valid  = 2'b01;
    step_ready = 1'b1;
    @(negedge c);
    req_valid = 2'b00;
    @(negedge c);
    step_ready = 1'b0;
    #1;
    vectors++;
    if (step_valid !== 1'b1 || pos !== 3'd7) begin
      $display("FAIL reset_pre: step_valid=%b pos=%0d want 1 and 7", step_valid, pos);
      miscompares++;
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({req_ready, step_valid, step_dir, busy, done, done_id, pos} !== 10'd0) begin
      $display("FAIL reset_midmove: outputs got %b want 0", {req_ready, step_valid, step_dir, busy, done, done_id, pos});
      miscompares++;
    end
    @(negedge c);
    rst = 1'b1;
    step_ready = 1'b1;
    m_pos = 3'd0;
    m_last = 1'b1;
    sb.delete();
    run_move(2'b01, 3'd2, 3'd0, 0, 1'b0, 2'b00, "after_reset_r0");
    run_move(2'b10, 3'd0, 3'd4, 0, 1'b0, 2'b00, "after_reset_r1");
  endtask

  task automatic test_shortest_path();
    test_reset_idle();
    run_move(2'b01, 3'd5, 3'd0, 0, 1'b0, 2'b00, "back3");
    run_move(2'b10, 3'd0, 3'd1, 0, 1'b0, 2'b00, "tie4");
  endtask

  task automatic test_zero_distance();
    run_move(2'b01, 3'd3, 3'd0, 0, 1'b0, 2'b00, "to3");
    run_move(2'b10, 3'd0, 3'd3, 0, 1'b0, 2'b00, "zero");
  endtask

  task automatic test_backpressure();
    run_move(2'b01, m_pos + 3'd2, 3'd0, 3, 1'b0, 2'b00, "stall3");
  endtask

  task automatic test_round_robin();
    test_reset_idle();
    for (int i = 0; i < 4; i++) begin
      run_move(2'b11, 3'd3, 3'd6, 0, 1'b1, 2'b00, "rr");
    end
    req_valid = 2'b00;
    run_move(2'b01, 3'd1, 3'd4, 0, 1'b0, 2'b10, "late_first");
    run_move(2'b10, 3'd1, 3'd4, 0, 1'b0, 2'b00, "late_served");
  endtask

  task automatic test_wrap();
    run_move(2'b01, 3'd7, 3'd0, 0, 1'b0, 2'b00, "to7");
    run_move(2'b10, 3'd0, 3'd0, 0, 1'b0, 2'b00, "wrap_fwd");
    run_move(2'b01, 3'd7, 3'd0, 0, 1'b0, 2'b00, "wrap_back");
  endtask

  initial begin
    test_reset();
    test_shortest_path();
    test_zero_distance();
    test_backpressure();
    test_round_robin();
    test_wrap();
    @(negedge c);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
